pmem_responder: RTL and testbench

PMEM_RESPONDER -- requirements
Module: pmem_responder

---
 rtl/lc3b_types.sv | 16 +
 rtl/pmem_array.sv | 52 +++++
 rtl/pmem_responder.sv | 118 +++++++++++
 tb/tb_pmem_responder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b memory-side types: word/line widths, responder FSM states and
// the default response latency.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } lc3b_pmem_state_t;

  localparam int PMEM_LATENCY = 4;

endpackage

// File: rtl/pmem_array.sv
// Line storage: one registered read port, one write port. Per-line valid bits
// give an instant clear on reset while the data array itself stays resetless.
module pmem_array
  import lc3b_types::*;
#(
  parameter int INDEX_BITS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [INDEX_BITS-1:0] windex,
  input  lc3b_line              wdata,
  input  logic                  re,
  input  logic [INDEX_BITS-1:0] rindex,
  output lc3b_line              rdata
);

  localparam int DEPTH = 2 ** INDEX_BITS;

  lc3b_line         mem [0:DEPTH-1];
  logic [DEPTH-1:0] valid_reg;
  lc3b_line         q_reg;
  logic             q_valid_reg;

  always_ff @(posedge clk) begin
    if (we) mem[windex] <= wdata;
    if (re) q_reg <= mem[rindex];
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_valid
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          valid_reg[gi] <= 1'b0;
        else if (we && (windex == INDEX_BITS'(gi)))
          valid_reg[gi] <= 1'b1;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      q_valid_reg <= 1'b0;
    else if (re)
      q_valid_reg <= valid_reg[rindex];
  end

  // Never-written lines read as zero; q_reg is only trusted when its line was valid.
  assign rdata = q_valid_reg ? q_reg : '0;

endmodule

// File: rtl/pmem_responder.sv
// Physical-memory responder: accepts one line read/write, answers after a fixed
// latency with a single-cycle pmem_resp, and flags protocol violations.
module pmem_responder
  import lc3b_types::*;
#(
  parameter int LATENCY    = PMEM_LATENCY,
  parameter int INDEX_BITS = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     pmem_read,
  input  logic     pmem_write,
  input  lc3b_word pmem_address,
  input  lc3b_line pmem_wdata,
  output logic     pmem_resp,
  output lc3b_line pmem_rdata,
  output logic     proto_err
);

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  lc3b_pmem_state_t      state_reg, state_next;
  logic [3:0]            cnt_reg, cnt_next;
  logic                  op_write_reg;
  logic [INDEX_BITS-1:0] index_reg;
  lc3b_line              wdata_reg;
  logic                  proto_err_reg;

  logic                  accept;
  logic                  held;
  logic                  arr_we, arr_re;
  logic [INDEX_BITS-1:0] addr_index;
  logic [INDEX_BITS-1:0] rindex;
  logic                  unused_addr;

  assign addr_index  = pmem_address[4+INDEX_BITS-1:4];
  assign unused_addr = ^pmem_address;
  assign accept      = (state_reg == IDLE) && (pmem_read || pmem_write);
  assign held        = op_write_reg ? pmem_write : pmem_read;

  // The array is read on the edge that enters RESP, so its output register is
  // pmem_rdata and holds until the next read response. With LATENCY 1 that edge
  // is the accepting one, so the index comes straight from the bus.
  assign rindex = (LATENCY == 1) ? addr_index : index_reg;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    arr_we     = 1'b0;
    arr_re     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_next = RESP;
            arr_re     = !pmem_write;
          end else begin
            state_next = BUSY;
            cnt_next   = CNT_LOAD;
          end
        end
      end
      BUSY: begin
        if (cnt_reg <= 4'd1) begin
          state_next = RESP;
          cnt_next   = 4'd0;
          arr_re     = !op_write_reg;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      RESP: begin
        state_next = IDLE;
        arr_we     = op_write_reg;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= 4'd0;
      op_write_reg  <= 1'b0;
      index_reg     <= '0;
      wdata_reg     <= '0;
      proto_err_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        op_write_reg <= pmem_write;
        index_reg    <= addr_index;
        wdata_reg    <= pmem_wdata;
        if (pmem_read && pmem_write) proto_err_reg <= 1'b1;
      end
      // Requester dropped its request before seeing the response.
      if ((state_reg == BUSY) && !held) proto_err_reg <= 1'b1;
    end
  end

  pmem_array #(
    .INDEX_BITS(INDEX_BITS)
  ) u_array (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (arr_we),
    .windex (index_reg),
    .wdata  (wdata_reg),
    .re     (arr_re),
    .rindex (rindex),
    .rdata  (pmem_rdata)
  );

  assign pmem_resp = (state_reg == RESP);
  assign proto_err = proto_err_reg;

endmodule

// File: tb/tb_pmem_responder.sv
// Directed bench: table of L=4 transactions plus hand sequences for reset abort,
// early deassertion and back-to-back LATENCY=1 reads.
module tb_pmem_responder;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         pmem_read, pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic         pmem_resp;
  logic [127:0] pmem_rdata;
  logic         proto_err;

  logic         r1_read, r1_write;
  logic [15:0]  r1_address;
  logic [127:0] r1_wdata;
  logic         r1_resp;
  logic [127:0] r1_rdata;
  logic         r1_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pmem_responder #(.LATENCY(4), .INDEX_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp),
    .pmem_rdata(pmem_rdata), .proto_err(proto_err)
  );

  pmem_responder #(.LATENCY(1), .INDEX_BITS(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .pmem_read(r1_read), .pmem_write(r1_write),
    .pmem_address(r1_address), .pmem_wdata(r1_wdata), .pmem_resp(r1_resp),
    .pmem_rdata(r1_rdata), .proto_err(r1_err)
  );

  typedef struct {
    logic         rd;
    logic         wr;
    logic [15:0]  addr;
    logic [127:0] wdata;
    bit           b2b;
    int           cycles;
    logic [127:0] rdata;
    logic         err;
  } vec_t;

  localparam logic [127:0] D1 = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] DA = 128'hAAAA5555AAAA5555AAAA5555AAAA5555;
  localparam logic [127:0] DB = 128'hBBBB0000BBBB1111BBBB2222BBBB3333;
  localparam logic [127:0] DC = 128'hCCCCCCCC00000000CCCCCCCC11111111;
  localparam logic [127:0] DD = 128'hDDDD0001DDDD0002DDDD0003DDDD0004;

  vec_t vecs[8];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wait_resp(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!pmem_resp && n < 20);
  endtask

  task automatic wait_resp1(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!r1_resp && n < 20);
  endtask

  task automatic idle_main();
    pmem_read = 1'b0; pmem_write = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int n;
    vecs[0] = '{1'b1, 1'b0, 16'h0040, '0, 1'b0, 4, '0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 16'h0120, D1, 1'b0, 4, '0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 16'h0128, '0, 1'b1, 5, D1, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 16'h1010, DA, 1'b0, 4, D1, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 16'h0010, '0, 1'b0, 4, DA, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 16'h0030, '0, 1'b0, 4, '0, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 16'h0200, DB, 1'b0, 4, '0, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 16'h0200, '0, 1'b0, 4, DB, 1'b1};

    rst_n = 1'b0;
    pmem_read = 1'b0; pmem_write = 1'b0; pmem_address = '0; pmem_wdata = '0;
    r1_read = 1'b0; r1_write = 1'b0; r1_address = '0; r1_wdata = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset_resp", 128'(pmem_resp), 128'(0));
    check("reset_rdata", pmem_rdata, '0);
    check("reset_err", 128'(proto_err), 128'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Table of L=4 transactions; b2b entries are driven in the RESP cycle.
    for (int i = 0; i < 8; i++) begin
      if (!vecs[i].b2b) idle_main();
      pmem_read = vecs[i].rd; pmem_write = vecs[i].wr;
      pmem_address = vecs[i].addr; pmem_wdata = vecs[i].wdata;
      wait_resp(n);
      $display("[TB] vec %0d rd=%0d wr=%0d addr=%h cycles=%0d rdata=%h err=%0d",
               i, vecs[i].rd, vecs[i].wr, vecs[i].addr, n, pmem_rdata, proto_err);
      check($sformatf("vec%0d_cycles", i), 128'(n), 128'(vecs[i].cycles));
      check($sformatf("vec%0d_rdata", i), pmem_rdata, vecs[i].rdata);
      check($sformatf("vec%0d_err", i), 128'(proto_err), 128'(vecs[i].err));
    end
    idle_main();

    // Reset two cycles into a write: no response, outputs cleared, write lost.
    pmem_write = 1'b1; pmem_address = 16'h0300; pmem_wdata = DC;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0; pmem_write = 1'b0;
    @(negedge clk);
    check("abort_resp", 128'(pmem_resp), 128'(0));
    check("abort_rdata", pmem_rdata, '0);
    check("abort_err", 128'(proto_err), 128'(0));
    rst_n = 1'b1;
    n = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (pmem_resp) n++;
    end
    $display("[TB] reset abort: stray resp count=%0d", n);
    check("abort_no_resp", 128'(n), 128'(0));
    pmem_read = 1'b1; pmem_address = 16'h0300;
    wait_resp(n);
    $display("[TB] read 0300 after abort cycles=%0d rdata=%h", n, pmem_rdata);
    check("abort_rd_cycles", 128'(n), 128'(4));
    check("abort_rd_0300", pmem_rdata, '0);
    idle_main();
    pmem_read = 1'b1; pmem_address = 16'h0200;
    wait_resp(n);
    $display("[TB] read 0200 after reset cycles=%0d rdata=%h err=%0d", n, pmem_rdata, proto_err);
    check("cleared_0200", pmem_rdata, '0);
    check("cleared_err", 128'(proto_err), 128'(0));
    idle_main();

    // Request dropped and bus changed mid-flight: latched write still completes.
    pmem_write = 1'b1; pmem_address = 16'h0400; pmem_wdata = DD;
    @(negedge clk);
    pmem_write = 1'b0; pmem_address = 16'h0500; pmem_wdata = DA;
    n = 1;
    while (!pmem_resp && n < 20) begin
      @(negedge clk);
      n++;
    end
    $display("[TB] early drop write 0400 cycles=%0d err=%0d", n, proto_err);
    check("drop_cycles", 128'(n), 128'(4));
    check("drop_err", 128'(proto_err), 128'(1));
    idle_main();
    pmem_read = 1'b1; pmem_address = 16'h0400;
    wait_resp(n);
    $display("[TB] read 0400 cycles=%0d rdata=%h", n, pmem_rdata);
    check("drop_rd_0400", pmem_rdata, DD);
    idle_main();
    pmem_read = 1'b1; pmem_address = 16'h0500;
    wait_resp(n);
    $display("[TB] read 0500 cycles=%0d rdata=%h", n, pmem_rdata);
    check("drop_rd_0500", pmem_rdata, '0);
    idle_main();

    // LATENCY=1 instance: fill three lines, then one continuously held read.
    for (int i = 0; i < 3; i++) begin
      r1_write = 1'b1; r1_address = 16'h0050 + 16'(i * 16);
      r1_wdata = {4{32'hF00D0000 + 32'(i)}};
      wait_resp1(n);
      $display("[TB] L1 write %h cycles=%0d", r1_address, n);
      check($sformatf("l1_wr%0d_cycles", i), 128'(n), 128'(1));
      r1_write = 1'b0;
      @(negedge clk);
    end
    r1_read = 1'b1; r1_address = 16'h0050;
    for (int i = 0; i < 3; i++) begin
      wait_resp1(n);
      $display("[TB] L1 read %h cycles=%0d rdata=%h", r1_address, n, r1_rdata);
      check($sformatf("l1_rd%0d_cycles", i), 128'(n), 128'((i == 0) ? 1 : 2));
      check($sformatf("l1_rd%0d_rdata", i), r1_rdata, {4{32'hF00D0000 + 32'(i)}});
      r1_address = 16'h0060 + 16'(i * 16);
    end
    r1_read = 1'b0;
    @(negedge clk);
    check("l1_err", 128'(r1_err), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
